// File: rtl/clock_group_reset_sequencer_pkg.sv
// Shared definitions for the clock group reset sequencer.
package clock_group_pkg;

    localparam int N_MEMBERS_DFLT = 5;

    // Member index order on the clock group aggregator
    localparam int MEMBER_SBUS = 0;
    localparam int MEMBER_CBUS = 1;
    localparam int MEMBER_FBUS = 2;
    localparam int MEMBER_L2_0 = 3;
    localparam int MEMBER_L2_1 = 4;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        GAP     = 2'd2,
        IDLE    = 2'd3
    } state_t;

endpackage

// File: rtl/clock_group_reset_sequencer_if.sv
// Request handshake and member reset outputs of the sequencer.
interface clock_group_reset_sequencer_if #(
    parameter int N_MEMBERS = clock_group_pkg::N_MEMBERS_DFLT
);
    logic [N_MEMBERS-1:0] io_members_reset;
    logic                 io_req_valid;
    logic                 io_req_ready;
    logic [N_MEMBERS-1:0] io_req_bits_mask;
    logic                 io_done;
    logic                 io_all_released;

    // Requester side
    modport master (
        output io_req_valid, io_req_bits_mask,
        input  io_req_ready, io_members_reset, io_done, io_all_released
    );

    // Sequencer side
    modport slave (
        input  io_req_valid, io_req_bits_mask,
        output io_req_ready, io_members_reset, io_done, io_all_released
    );
endinterface

// File: rtl/clock_group_reset_sequencer_lowest_set_bit_sel.sv
// Picks the lowest set bit of a mask as a one-hot vector.
module lowest_set_bit_sel #(
    parameter int N = 5
) (
    input  logic [N-1:0] mask,
    output logic [N-1:0] onehot,
    output logic         valid
);
    // Two's complement trick isolates the lowest set bit
    assign onehot = mask & (~mask + N'(1));
    assign valid  = |mask;
endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Holds clock group members in reset, then releases them one by one
// in ascending index order with a fixed spacing; software may re-run
// the sequence on a subset of members.
module clock_group_reset_sequencer
    import clock_group_pkg::*;
#(
    parameter int N_MEMBERS   = N_MEMBERS_DFLT,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 8,
    parameter int CNT_W       = $clog2((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1
) (
    input  logic                          clock,
    input  logic                          reset,
    clock_group_reset_sequencer_if.slave  bus
);

    if (N_MEMBERS < 1) begin : g_bad_members
        $error("N_MEMBERS must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 2) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 2");
    end

    // HOLD exits on its last count; GAP exits one early because the
    // RELEASE cycle itself is part of the spacing between release edges.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 2);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_MEMBERS-1:0] pending_q, pending_d;
    logic [N_MEMBERS-1:0] members_q, members_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 all_rel_q, all_rel_d;
    logic [N_MEMBERS-1:0] sel_onehot;
    logic                 sel_valid;
    logic [N_MEMBERS-1:0] pend_left;

    lowest_set_bit_sel #(.N(N_MEMBERS)) u_sel (
        .mask   (pending_q),
        .onehot (sel_onehot),
        .valid  (sel_valid)
    );

    // State, counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            pending_q <= '1;
            members_q <= '1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            members_q <= members_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            all_rel_q <= all_rel_d;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        members_d = members_q;
        done_d    = 1'b0;
        pend_left = pending_q & ~sel_onehot;
        case (state_q)
            HOLD: begin
                if (cnt_q >= HOLD_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                members_d = members_q & ~sel_onehot;
                pending_d = pend_left;
                cnt_d     = '0;
                if (sel_valid && pend_left != '0) begin
                    state_d = GAP;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (bus.io_req_valid && ready_q) begin
                    if (bus.io_req_bits_mask != '0) begin
                        // The accept cycle counts as the first hold cycle so
                        // releases line up with the power-on timing from t.
                        members_d = members_q | bus.io_req_bits_mask;
                        pending_d = bus.io_req_bits_mask;
                        cnt_d     = CNT_W'(1);
                        state_d   = HOLD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
        endcase
        ready_d   = (state_d == IDLE);
        all_rel_d = (state_d == IDLE) && (members_d == '0);
    end

    assign bus.io_members_reset = members_q;
    assign bus.io_req_ready     = ready_q;
    assign bus.io_done          = done_q;
    assign bus.io_all_released  = all_rel_q;

endmodule

// File: doc/clock_group_reset_sequencer.md
Name: clock_group_reset_sequencer

Overview:
- Sits on the source side of the clock group aggregator and drives the member reset fields of each clock group member.
- Member order: 0=sbus, 1=cbus, 2=fbus, 3=l2_0, 4=l2_1.
- After system reset it holds every member in reset, then releases the members one at a time in ascending index order, with a fixed spacing between releases.
- Also accepts software requests to re-reset a chosen subset of members and run the same hold/release sequence on that subset only.

Parameters:
- N_MEMBERS, 5, number of clock group members driven.
- HOLD_CYCLES, 4, minimum cycles a member reset stays asserted before its release sequence starts; must be ≥1.
- GAP_CYCLES, 8, exact cycle spacing between successive release edges; must be ≥2.
- CNT_W, $clog2(max(HOLD_CYCLES,GAP_CYCLES))+1, width of the internal counter.

Ports:
- clock  in  1  single block clock.
- reset  in  1  synchronous, active-high.
- io_members_reset  out  N_MEMBERS  per-member reset; bit i drives member i's reset field.
- io_req_valid  in  1  re-reset request valid.
- io_req_ready  out  1  request can be accepted.
- io_req_bits_mask  in  N_MEMBERS  members to re-reset.
- io_done  out  1  one-cycle pulse when a sequence completes.
- io_all_released  out  1  high when no member reset is asserted and the block is idle.

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high.
- All outputs are registered.
- While reset=1:
  - io_members_reset = all ones; io_req_ready=0; io_done=0; io_all_released=0.
  - State = HOLD, counter = 0, pending mask = all ones.
- States:
  - HOLD: counter counts 0..HOLD_CYCLES-1, then go to RELEASE.
  - RELEASE: clear the io_members_reset bit of the lowest set bit of pending and clear that bit in pending. If pending is then nonzero, go to GAP; otherwise go to IDLE.
  - GAP: counter counts so that consecutive release edges on io_members_reset are exactly GAP_CYCLES apart, then go to RELEASE.
  - IDLE: io_req_ready=1; io_all_released=1 only if io_members_reset==0.
- Power-on timing, with cycle 0 = first cycle with reset=0:
  - Member k's reset is first observed low at cycle HOLD_CYCLES+1+k*GAP_CYCLES.
  - Defaults: k=0..4 → cycles 5, 13, 21, 29, 37.
  - io_done pulses, and io_req_ready and io_all_released rise, in the same cycle the last release is observed (37).
- Request accepted when io_req_valid && io_req_ready, in accept cycle t:
  - mask≠0:
    - At t+1: masked reset bits go high and unmasked bits are unchanged; pending=mask; io_req_ready=0; io_all_released=0; state=HOLD.
    - Release edges then follow the power-on timing relative to t, using only the set mask bits in ascending order.
    - Unmasked indices are skipped and consume no gap.
    - Example, mask=0b10100: bit2 low at t+5, bit4 low at t+13.
  - mask=0: io_done pulses at t+1; no other output changes; io_req_ready stays 1.
- io_req_valid while not IDLE: not accepted (ready=0). The requester holds valid; no queuing.
- io_done: exactly one pulse per completed sequence (power-on or request). Never asserted during HOLD or GAP.
- Reset asserted mid-sequence (any state): next cycle outputs equal the reset values; the full all-member sequence restarts when reset drops.
- Counter saturates and never wraps. An out-of-range parameter is an elaboration error.

Decomposition:
- Shared package clock_group_pkg:
  - N_MEMBERS default.
  - Member index constants MEMBER_SBUS=0, MEMBER_CBUS=1, MEMBER_FBUS=2, MEMBER_L2_0=3, MEMBER_L2_1=4.
  - State enum {HOLD, RELEASE, GAP, IDLE}.
- One sub-module: lowest_set_bit_sel. Combinational; N-bit mask in, one-hot of the lowest set bit plus a valid flag out. Reused for release ordering.

Test Plan:
- Power-on, defaults: reset low at cycle 0 → io_members_reset goes 0x1F→0x1E@5→0x1C@13→0x18@21→0x10@29→0x00@37; io_done=1 only @37; ready=1 from 37.
- Request mask=0b00110 accepted @t → io_members_reset=0x06@t+1; bit1 low @t+5, bit2 low @t+13; done @t+13; bits 0, 3 and 4 never toggle.
- Request mask=0 accepted @t → io_done=1 @t+1 only; io_members_reset stays 0x00; ready stays 1.
- io_req_valid held high from cycle 2 of power-on → not accepted until cycle 37; accepted there; masked bits high @38.
- Reset pulsed at cycle 20 mid power-on → @21 io_members_reset=0x1F, ready=0, done=0; restart timing measured from reset deassertion.
- HOLD_CYCLES=1, GAP_CYCLES=2, N_MEMBERS=5 → releases @2, 4, 6, 8, 10; done @10.
